// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
// Contents: WIDTH (operand width), CNT_W (iteration counter width),
//           state_t (IDLE/PREP/ITER/FIX/DONE), abs_val() magnitude helper.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    // Magnitude of a two's-complement value; the most negative value maps
    // to 2^(WIDTH-1), which is exact when the result is read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/seq_divider32_if.sv
// rtl/seq_divider32_if.sv - request/result bundle of the sequential divider
// Signals: start, is_signed, dividend, divisor (requester -> divider);
//          busy, done, quotient, remainder, div_by_zero, overflow (divider -> requester).
// Macro: DIVIDER_OVERFLOW_FLAG_EN adds the overflow signal.
interface seq_divider32_if;
    import div_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIVIDER_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    modport master (
`ifdef DIVIDER_OVERFLOW_FLAG_EN
        input  overflow,
`endif
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef DIVIDER_OVERFLOW_FLAG_EN
        output overflow,
`endif
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - one restoring-division trial subtract
// Ports: partial  in  WIDTH+1  shifted partial remainder
//        divisor  in  WIDTH    divisor magnitude
//        diff     out WIDTH    partial - divisor (valid when nonneg)
//        nonneg   out 1        trial result is non-negative
module div_sub_step
    import div_pkg::*;
(
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             nonneg
);

    // The trial is WIDTH+1 bits wide; when it is non-negative it is
    // smaller than the divisor, so its top bit is zero and the low WIDTH
    // bits carry the whole new remainder.
    assign nonneg = (partial >= {1'b0, divisor});
    assign diff   = partial[WIDTH-1:0] - divisor;

endmodule

// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle restoring 32-bit signed/unsigned divider
// Ports: clk    in  rising-edge clock
//        rst_n  in  asynchronous active-low reset
//        bus    seq_divider32_if.slave (start/operands in, busy/done/results out)
// Macro: DIVIDER_OVERFLOW_FLAG_EN enables the overflow flag (-2^31 / -1 signed).
module seq_divider32
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    seq_divider32_if.slave bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_w;    // partial remainder
    logic [WIDTH-1:0] quo_w;    // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr;
    logic             sgn, q_neg, r_neg, dbz_w;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_ok;
    logic             accept;
`ifdef DIVIDER_OVERFLOW_FLAG_EN
    logic             ovf_w;
`endif

    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy = (state != IDLE);

    // {rem, quo} shifted left by one: the remainder gains the next dividend bit.
    assign partial = {rem_w, quo_w[WIDTH-1]};

    div_sub_step u_step (
        .partial (partial),
        .divisor (dvsr),
        .diff    (trial_diff),
        .nonneg  (trial_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : PREP;
            PREP: state_nxt = ITER;
            ITER: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_w           <= '0;
            quo_w           <= '0;
            dvsr            <= '0;
            sgn             <= 1'b0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            dbz_w           <= 1'b0;
            cnt             <= '0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
`ifdef DIVIDER_OVERFLOW_FLAG_EN
            ovf_w           <= 1'b0;
            bus.overflow    <= 1'b0;
`endif
        end else begin
            // done is registered from the DONE state so results and the
            // pulse appear together, one cycle after DONE is entered.
            bus.done <= (state == DONE);
            case (state)
                IDLE: if (accept) begin
                    dvsr  <= bus.divisor;
                    sgn   <= bus.is_signed;
                    cnt   <= '0;
                    dbz_w <= (bus.divisor == '0);
                    if (bus.divisor == '0) begin
                        // Iteration skipped: results are final right away.
                        quo_w <= '1;
                        rem_w <= bus.dividend;
                    end else begin
                        quo_w <= bus.dividend;
                        rem_w <= '0;
                    end
`ifdef DIVIDER_OVERFLOW_FLAG_EN
                    ovf_w <= bus.is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                             && (bus.divisor == '1);
`endif
                end
                PREP: begin
                    if (sgn) begin
                        q_neg <= quo_w[WIDTH-1] ^ dvsr[WIDTH-1];
                        r_neg <= quo_w[WIDTH-1];
                        quo_w <= abs_val(quo_w);
                        dvsr  <= abs_val(dvsr);
                    end else begin
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end
                end
                ITER: begin
                    rem_w <= trial_ok ? trial_diff : partial[WIDTH-1:0];
                    quo_w <= {quo_w[WIDTH-2:0], trial_ok};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (q_neg) quo_w <= -quo_w;
                    if (r_neg) rem_w <= -rem_w;
                end
                DONE: begin
                    bus.quotient    <= quo_w;
                    bus.remainder   <= rem_w;
                    bus.div_by_zero <= dbz_w;
`ifdef DIVIDER_OVERFLOW_FLAG_EN
                    bus.overflow    <= ovf_w;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - directed table-driven bench for seq_divider32
module tb_seq_divider32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_divider32_if bus ();

    seq_divider32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with busy low. Returns at the negedge where done
    // is seen (or after the cycle budget), with lat = edges after acceptance.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic chk_result(input string name, input logic [31:0] q, input logic [31:0] r,
                              input logic dbz, input logic ovf, input int exp_lat, input int lat);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " done"}, {31'd0, bus.done}, 32'd1);
        chk({name, " quotient"}, bus.quotient, q);
        chk({name, " remainder"}, bus.remainder, r);
        chk({name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, dbz});
        chk({name, " busy"}, {31'd0, bus.busy}, 32'd0);
`ifdef DIVIDER_OVERFLOW_FLAG_EN
        chk({name, " overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
`else
        if (ovf) begin end
`endif
    endtask

    initial begin
        int lat;
        int seen_done;
        vecs[0]  = '{"u 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 35};
        vecs[1]  = '{"s -100/7",       1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 35};
        vecs[2]  = '{"s 100/-7",       1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 35};
        vecs[3]  = '{"u 0x1234/0",     1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1};
        vecs[4]  = '{"s min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 35};
        vecs[5]  = '{"u min/-1",       1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0, 35};
        vecs[6]  = '{"u ffffffff/16",  1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0, 1'b0, 35};
        vecs[7]  = '{"s -7/-2",        1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 1'b0, 35};
        vecs[8]  = '{"u 5/9",          1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 35};
        vecs[9]  = '{"u max/max-1",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0, 1'b0, 35};
        vecs[10] = '{"s -100/0",       1'b1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1, 1'b0, 1};
        vecs[11] = '{"s min/1",        1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0, 35};

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
        chk("reset div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
`ifdef DIVIDER_OVERFLOW_FLAG_EN
        chk("reset overflow", {31'd0, bus.overflow}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            chk_result(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].lat, lat);
            @(negedge clk);
            chk({vecs[i].name, " done pulse width"}, {31'd0, bus.done}, 32'd0);
            chk({vecs[i].name, " results held"}, bus.quotient, vecs[i].q);
        end

        // start while busy is ignored
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
        chk_result("busy start", 32'd333, 32'd1, 1'b0, 1'b0, 35, lat);
        @(negedge clk);
        chk("busy start no second op", {31'd0, bus.busy}, 32'd0);

        // start coincident with done
        do_op(1'b0, 32'd50, 32'd5, lat);
        chk_result("first of pair", 32'd10, 32'd0, 1'b0, 1'b0, 35, lat);
        do_op(1'b0, 32'd77, 32'd10, lat);
        chk_result("start on done", 32'd7, 32'd7, 1'b0, 1'b0, 35, lat);
        @(negedge clk);

        // asynchronous reset mid-operation
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd123; bus.divisor = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset quotient", bus.quotient, 32'd0);
        chk("midreset remainder", bus.remainder, 32'd0);
        chk("midreset done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        chk("midreset no done", 32'(seen_done), 32'd0);
        do_op(1'b0, 32'hFFFFFFFF, 32'h10, lat);
        chk_result("after reset", 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 35, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
